// File: rtl/large_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : large_mul_pkg
// Purpose  : Shared types and constants for the large multiplier sequencer:
//            state encoding, default operand/slice widths and a helper that
//            sizes the pass counter.
// Revision : 1.0 - initial release
// ============================================================================
package large_mul_pkg;

  // Default operand width, engine slice width and resulting pass count.
  localparam int DEF_W = 1024;
  localparam int DEF_K = 32;
  localparam int DEF_N = DEF_W / DEF_K;

  // Sequencer control states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACCUM = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Width of a counter that indexes n passes; never narrower than one bit.
  function automatic int pass_width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_accum_window.sv
`default_nettype none
// ============================================================================
// Module   : mul_accum_window
// Purpose  : Combinational accumulate-and-split step of the shifting window.
//            Adds one partial product to the running upper accumulator,
//            emits the finished low K-bit chunk and the shifted accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module mul_accum_window
  import large_mul_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int K = DEF_K
) (
  input  logic [W-1:0]   acc_i,
  input  logic [W+K-1:0] prod_i,
  output logic [K-1:0]   chunk_o,
  output logic [W-1:0]   acc_next_o
);

  // acc < 2^W and prod <= (2^W-1)(2^K-1), so the sum always fits in W+K bits.
  logic [W+K-1:0] w_sum;

  assign w_sum      = {{K{1'b0}}, acc_i} + prod_i;
  assign chunk_o    = w_sum[K-1:0];
  assign acc_next_o = w_sum[W+K-1:K];

endmodule
`default_nettype wire

// File: rtl/large_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : large_mul_sequencer
// Purpose  : Computes a full W x W unsigned product by running a shared
//            W x K serial engine once per K-bit multiplier slice and
//            accumulating the partial products in a shifting window.
//            Zero slices bypass the engine entirely.
// Revision : 1.0 - initial release
// ============================================================================
module large_mul_sequencer
  import large_mul_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int K = DEF_K
) (
  input  logic             clk,
  input  logic             rstn,
  // operand stream
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  // result stream
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  // serial engine
  output logic             eng_start,
  output logic [W-1:0]     eng_in1,
  output logic [K-1:0]     eng_in2,
  input  logic             eng_done,
  input  logic [W+K-1:0]   eng_prod,
  output logic             busy
);

  localparam int N  = W / K;
  localparam int PW = pass_width(N);

  state_e            state_q, state_d;
  logic              rdy_q;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [PW-1:0]     pass_q, pass_d;
  logic [W-1:0]      acc_q, acc_d;
  logic [W-1:0]      lo_q, lo_d;
  logic [W+K-1:0]    prod_q, prod_d;
  logic [2*W-1:0]    out_p_q, out_p_d;
  logic              out_valid_q, out_valid_d;

  logic [K-1:0]      w_slice;
  logic [K-1:0]      w_chunk;
  logic [W-1:0]      w_acc_next;
  logic [W-1:0]      w_lo_ins;

  // Current multiplier slice; also what the engine sees as its multiplier,
  // so it is stable for as long as the pass index and b_q are.
  assign w_slice   = b_q[K*pass_q +: K];

  assign eng_in1   = a_q;
  assign eng_in2   = w_slice;
  assign out_p     = out_p_q;
  assign out_valid = out_valid_q;
  // rdy_q holds in_ready low for the first cycle out of reset.
  assign in_ready  = rdy_q && (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

  mul_accum_window #(
    .W (W),
    .K (K)
  ) u_window (
    .acc_i      (acc_q),
    .prod_i     (prod_q),
    .chunk_o    (w_chunk),
    .acc_next_o (w_acc_next)
  );

  // Low-half image with this pass's finished chunk dropped into place.
  always_comb begin
    w_lo_ins                 = lo_q;
    w_lo_ins[K*pass_q +: K]  = w_chunk;
  end

  // Control and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      rdy_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      pass_q      <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      prod_q      <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= 1'b1;
      a_q         <= a_d;
      b_q         <= b_d;
      pass_q      <= pass_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      prod_q      <= prod_d;
      out_p_q     <= out_p_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath updates for the pass sequencer.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    pass_d      = pass_q;
    acc_d       = acc_q;
    lo_d        = lo_q;
    prod_d      = prod_q;
    out_p_d     = out_p_q;
    out_valid_d = out_valid_q;
    eng_start   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          lo_d    = '0;
          pass_d  = '0;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (w_slice == '0) begin
          // Nothing to multiply: feed a zero partial product straight in.
          prod_d  = '0;
          state_d = ST_ACCUM;
        end else begin
          eng_start = 1'b1;
          state_d   = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (eng_done) begin
          prod_d  = eng_prod;
          state_d = ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        acc_d = w_acc_next;
        lo_d  = w_lo_ins;
        if (pass_q == PW'(N - 1)) begin
          out_p_d     = {w_acc_next, w_lo_ins};
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          pass_d  = pass_q + PW'(1);
          state_d = ST_ISSUE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_large_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_large_mul_sequencer
// Purpose  : Self-checking bench for large_mul_sequencer. A 64x16 instance is
//            exercised with directed and randomized operands against a plain
//            a*b reference, with a behavioural engine of selectable latency;
//            a 1024x32 instance gets a closing smoke test.
// Revision : 1.0 - initial release
// ============================================================================
module tb_large_mul_sequencer;

  localparam int W  = 64;
  localparam int K  = 16;
  localparam int BW = 1024;
  localparam int BK = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  // clock generation
  always #5 clk = ~clk;

  // ---------------- small instance ----------------
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a      = '0;
  logic [W-1:0]     in_b      = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2*W-1:0]   out_p;
  logic             eng_start;
  logic [W-1:0]     eng_in1;
  logic [K-1:0]     eng_in2;
  logic             eng_done;
  logic             eng_done_m;
  logic [W+K-1:0]   eng_prod;
  logic             busy;
  logic             spur      = 1'b0;

  assign eng_done = eng_done_m | spur;

  large_mul_sequencer #(.W(W), .K(K)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .eng_start (eng_start),
    .eng_in1   (eng_in1),
    .eng_in2   (eng_in2),
    .eng_done  (eng_done),
    .eng_prod  (eng_prod),
    .busy      (busy)
  );

  // ---------------- full-width instance ----------------
  logic             b_in_valid  = 1'b0;
  logic             b_in_ready;
  logic [BW-1:0]    b_in_a      = '0;
  logic [BW-1:0]    b_in_b      = '0;
  logic             b_out_valid;
  logic             b_out_ready = 1'b0;
  logic [2*BW-1:0]  b_out_p;
  logic             b_eng_start;
  logic [BW-1:0]    b_eng_in1;
  logic [BK-1:0]    b_eng_in2;
  logic             b_eng_done;
  logic [BW+BK-1:0] b_eng_prod;
  logic             b_busy;

  large_mul_sequencer #(.W(BW), .K(BK)) dut_big (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_a      (b_in_a),
    .in_b      (b_in_b),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_p     (b_out_p),
    .eng_start (b_eng_start),
    .eng_in1   (b_eng_in1),
    .eng_in2   (b_eng_in2),
    .eng_done  (b_eng_done),
    .eng_prod  (b_eng_prod),
    .busy      (b_busy)
  );

  int n_cmp     = 0;
  int n_bad     = 0;
  int eng_lat   = 3;
  int start_cnt = 0;
  int eng_cnt;
  int b_eng_cnt;
  logic [W-1:0] cap1;
  logic [K-1:0] cap2;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural engine: done pulses eng_lat cycles after the start cycle,
  // with the product of the operands seen at start.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      eng_cnt    <= 0;
      eng_done_m <= 1'b0;
      eng_prod   <= '0;
    end else begin
      eng_done_m <= 1'b0;
      if (eng_start) begin
        start_cnt <= start_cnt + 1;
        cap1      <= eng_in1;
        cap2      <= eng_in2;
        eng_prod  <= (W+K)'(eng_in1) * (W+K)'(eng_in2);
        eng_cnt   <= eng_lat - 1;
        if (eng_lat == 1) eng_done_m <= 1'b1;
      end else if (eng_cnt != 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) begin
          eng_done_m <= 1'b1;
          chk("eng_hold", 128'({eng_in1, eng_in2}), 128'({cap1, cap2}));
        end
      end
    end
  end

  // Fixed 3-cycle engine for the full-width instance.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      b_eng_cnt  <= 0;
      b_eng_done <= 1'b0;
      b_eng_prod <= '0;
    end else begin
      b_eng_done <= 1'b0;
      if (b_eng_start) begin
        b_eng_prod <= (BW+BK)'(b_eng_in1) * (BW+BK)'(b_eng_in2);
        b_eng_cnt  <= 2;
      end else if (b_eng_cnt != 0) begin
        b_eng_cnt <= b_eng_cnt - 1;
        if (b_eng_cnt == 1) b_eng_done <= 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    while (!in_ready && t < 200) begin step(); t++; end
    chk("in_ready_wait", 128'(in_ready), 128'(1));
    in_a = a; in_b = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // cyc counts clock edges from the accepting edge to out_valid.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 500) begin step(); cyc++; end
    chk("out_valid_wait", 128'(out_valid), 128'(1));
  endtask

  task automatic take(input int stall);
    repeat (stall) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  128'(in_ready),  128'(0));
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_out_p"},     128'(out_p),     128'(0));
    chk({tag, "_eng_start"}, 128'(eng_start), 128'(0));
    chk({tag, "_eng_in1"},   128'(eng_in1),   128'(0));
    chk({tag, "_eng_in2"},   128'(eng_in2),   128'(0));
    chk({tag, "_busy"},      128'(busy),      128'(0));
  endtask

  // Global time limit so the run can never hang.
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int cyc;
    int s0;
    int t;
    logic [W-1:0]    a, b, a2, b2;
    logic [127:0]    exp;
    logic [BW-1:0]   ba, bb;
    logic [2*BW-1:0] bexp;

    // ---- reset state ----
    #1;
    chk_reset_outputs("rst");
    step(); step();
    rstn = 1'b1;
    step();
    chk("rst_in_ready_after", 128'(in_ready), 128'(1));

    // ---- basic: 3*5, only slice 0 uses the engine ----
    eng_lat = 3;
    s0 = start_cnt;
    send(64'd3, 64'd5);
    wait_valid(cyc);
    chk("basic_p",      128'(out_p),          128'd15);
    chk("basic_starts", 128'(start_cnt - s0), 128'd1);
    chk("basic_lat",    128'(cyc),            128'd12);
    take(0);

    // ---- max operands ----
    s0 = start_cnt;
    send('1, '1);
    wait_valid(cyc);
    chk("max_p",      128'(out_p), 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    chk("max_starts", 128'(start_cnt - s0), 128'd4);
    chk("max_lat",    128'(cyc),            128'd21);
    take(0);

    // ---- zero multiplier ----
    s0 = start_cnt;
    send({$urandom(), $urandom()}, 64'd0);
    wait_valid(cyc);
    chk("zero_p",      128'(out_p),          128'd0);
    chk("zero_starts", 128'(start_cnt - s0), 128'd0);
    chk("zero_lat",    128'(cyc),            128'd9);
    take(0);

    // ---- backpressure ----
    a  = {$urandom(), $urandom()} | 64'h1;
    b  = {$urandom(), $urandom()} | 64'h1;
    a2 = {$urandom(), $urandom()} | 64'h1;
    b2 = {$urandom(), $urandom()} | 64'h1;
    exp = 128'(a) * 128'(b);
    send(a, b);
    wait_valid(cyc);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin in_a = a2; in_b = b2; in_valid = 1'b1; end
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_out_p",     128'(out_p),     exp);
      chk("bp_in_ready",  128'(in_ready),  128'(0));
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_idle_ready", 128'(in_ready),  128'(1));
    chk("bp_idle_valid", 128'(out_valid), 128'(0));
    chk("bp_p_kept",     128'(out_p),     exp);
    step();
    in_valid = 1'b0;
    chk("bp_accepted", 128'(busy), 128'(1));
    wait_valid(cyc);
    chk("bp_second_p", 128'(out_p), 128'(a2) * 128'(b2));
    take(0);

    // ---- reset during WAIT of pass 2 ----
    eng_lat = 3;
    s0 = start_cnt;
    send({$urandom(), $urandom()} | 64'h1, 64'h0001_0002_0003_0004);
    t = 0;
    while ((start_cnt - s0) < 3 && t < 200) begin step(); t++; end
    chk("mid_reach_wait", 128'(start_cnt - s0), 128'd3);
    chk("mid_busy",       128'(busy),           128'(1));
    #2 rstn = 1'b0;
    #1;
    chk_reset_outputs("mid");
    step(); step();
    rstn = 1'b1;
    spur = 1'b1;
    step();
    spur = 1'b0;
    chk("spur_busy",  128'(busy),      128'(0));
    chk("spur_valid", 128'(out_valid), 128'(0));
    step();
    chk("spur_busy2", 128'(busy), 128'(0));
    send(64'd7, 64'd9);
    wait_valid(cyc);
    chk("post_rst_p", 128'(out_p), 128'd63);
    take(0);

    // ---- randomized operands, latencies and stalls ----
    for (int n = 0; n < 500; n++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      for (int s = 0; s < W / K; s++)
        if ($urandom_range(0, 3) == 0) b[s*K +: K] = '0;
      if ($urandom_range(0, 31) == 0) a = '0;
      eng_lat = $urandom_range(1, 8);
      send(a, b);
      wait_valid(cyc);
      chk("rand_p", 128'(out_p), 128'(a) * 128'(b));
      take($urandom_range(0, 3));
    end

    // ---- full-width smoke test ----
    for (int i = 0; i < BW / 32; i++) begin
      ba[i*32 +: 32] = $urandom();
      bb[i*32 +: 32] = $urandom();
    end
    bb[BK +: BK] = '0;
    bexp = (2*BW)'(ba) * (2*BW)'(bb);
    t = 0;
    while (!b_in_ready && t < 200) begin step(); t++; end
    chk("big_in_ready", 128'(b_in_ready), 128'(1));
    b_in_a = ba; b_in_b = bb; b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    t = 0;
    while (!b_out_valid && t < 2000) begin step(); t++; end
    chk("big_out_valid", 128'(b_out_valid), 128'(1));
    for (int i = 0; i < (2*BW) / 128; i++)
      chk("big_p", b_out_p[i*128 +: 128], bexp[i*128 +: 128]);
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
    chk("big_idle", 128'(b_busy), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/large_mul_sequencer.md
Name: large_mul_sequencer

Overview:
- Controller that computes a full W x W unsigned product by driving one shared W x K serial shift-add multiplier engine for N = W/K passes.
- Slices the multiplier into K-bit chunks, issues one chunk per pass to the engine, and accumulates the partial products in a shifting window.
- Sits between the 1024-bit large-multiplication top level (ready/valid operand stream) and the serial engine, which uses a start/done handshake.

Parameters:
- W, 1024, multiplicand/multiplier width; must be a multiple of K.
- K, 32, engine multiplier slice width.
- N, W/K (localparam), number of passes; pass counter width is clog2(N).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept operands.
- in_a  in  W  multiplicand.
- in_b  in  W  multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_p  out  2W  product in_a*in_b.
- eng_start  out  1  one-cycle start pulse to engine.
- eng_in1  out  W  engine multiplicand (latched a).
- eng_in2  out  K  engine multiplier slice.
- eng_done  in  1  one-cycle pulse; eng_prod is valid in the same cycle.
- eng_prod  in  W+K  engine product eng_in1*eng_in2.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, rstn=0): state=IDLE, in_ready=0 for the reset cycle then 1 in IDLE, out_valid=0, out_p=0, eng_start=0, eng_in1=0, eng_in2=0, busy=0, pass=0, acc=0.
- IDLE: in_ready=1. On in_valid&in_ready, latch a_r=in_a and b_r=in_b; clear acc (W bits) and lo (W bits); set pass=0; go to ISSUE.
- ISSUE: set slice = b_r[K*pass +: K].
  - If slice==0, skip the engine: go to ACCUM with prod=0 and no eng_start.
  - Otherwise drive eng_in1=a_r and eng_in2=slice, pulse eng_start for exactly 1 cycle, and go to WAIT.
- WAIT: hold eng_in1 and eng_in2 stable. On eng_done, capture prod=eng_prod and go to ACCUM.
  - eng_done outside WAIT is ignored.
  - There is no timeout.
- ACCUM (1 cycle):
  - sum = acc + prod, computed in W+K bits. It cannot overflow, since acc<2^W and prod<=(2^W-1)(2^K-1).
  - lo[K*pass +: K] = sum[K-1:0]; acc = sum >> K.
  - If pass==N-1, set out_p={acc_next, lo_next} and go to DONE. Otherwise pass++ and go to ISSUE.
- DONE: out_valid=1 and out_p held stable until out_ready. On out_valid&out_ready, clear out_valid and go to IDLE.
  - out_p keeps its last value after the transfer.
- in_ready=0 in every state except IDLE; inputs arriving while busy are not consumed.
- Latency with no zero slices: 1 (accept) + N*(1 ISSUE + engine latency + 1 ACCUM) cycles to out_valid. Each zero slice costs 2 cycles (ISSUE + ACCUM).
- Reset mid-operation: everything returns to reset values immediately and any pending eng_done is ignored. The engine is reset by the same rstn.
- Back-to-back: a new operand can be accepted in the cycle after the DONE handshake (IDLE), not in the same cycle.

Decomposition:
- Shared package large_mul_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, ACCUM, DONE};
  - constants W, K, N;
  - a pass-index width function.
- Sub-module mul_accum_window: the combinational sum/split, taking acc and prod and producing the K-bit low chunk and the next acc.
- The FSM and registers stay in large_mul_sequencer.

Test Plan:
Bench uses W=64, K=16 plus a behavioral engine model with a configurable 3-cycle latency. Run a full-width (1024/32) smoke test at the end.
- Basic: a=0x0000_0000_0000_0003, b=0x0000_0000_0000_0005 -> out_p=15.
  - Exactly one eng_start is issued (the other three slices are zero).
  - out_valid appears after 1+(1+3+1)+3*2 = 12 cycles.
- Max operands: a=b=2^64-1 -> out_p=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
  - Four engine starts.
  - Checks the carry chain at the no-overflow bound.
- Zero multiplier: b=0, any a -> out_p=0, no eng_start, out_valid after 9 cycles.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_p stay stable and in_ready=0. Assert in_valid with a new pair; it is accepted only after out_ready=1 completes the transfer.
- Reset mid-op: assert rstn=0 during WAIT of pass 2 -> all outputs are at reset values asynchronously. A spurious eng_done after release is ignored, and the next operation (a=7, b=9) yields 63.
- Random: 500 random pairs, each compared to a reference a*b, with random engine latency 1-8 and random out_ready stalls.
